// File: rtl/spi_target.sv
// SPI mode-0 target: 8-bit MSB-first frames with a one-deep tx holding register.
// Every SPI pin is brought into the clk domain through a 2-flop synchronizer.
module spi_target #(
  parameter logic [7:0] FILL_BYTE = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_clk_i,
  input  logic       spi_csn_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic       spi_miso_drive_o,
  input  logic [7:0] tx_byte_i,
  input  logic       tx_en_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_en_o,
  output logic       sel_start_o,
  output logic       sel_end_o,
  output logic       tx_underrun_o,
  output logic       busy_o
);

  logic       sclk_m, sclk_s, sclk_d;
  logic       csn_m, csn_s, csn_d;
  logic       mosi_m, mosi_s;
  logic [2:0] bit_cnt;
  logic [6:0] rx_sh;
  logic [7:0] tx_sh;
  logic [7:0] hold;
  logic       hold_valid;
  logic       rise, fall, sel_fall, sel_rise, load;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_m <= 1'b0;
      sclk_s <= 1'b0;
      sclk_d <= 1'b0;
      csn_m  <= 1'b1;
      csn_s  <= 1'b1;
      csn_d  <= 1'b1;
      mosi_m <= 1'b0;
      mosi_s <= 1'b0;
    end else begin
      sclk_m <= spi_clk_i;
      sclk_s <= sclk_m;
      sclk_d <= sclk_s;
      csn_m  <= spi_csn_i;
      csn_s  <= csn_m;
      csn_d  <= csn_s;
      mosi_m <= spi_mosi_i;
      mosi_s <= mosi_m;
    end
  end

  always_comb begin
    rise     = sclk_s & ~sclk_d & ~csn_s;
    fall     = ~sclk_s & sclk_d & ~csn_s;
    sel_fall = ~csn_s & csn_d;
    sel_rise = csn_s & ~csn_d;
    // The trailing SCLK fall of each byte doubles as the next byte's load.
    load     = sel_fall | (fall & (bit_cnt == 3'd0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt          <= '0;
      rx_sh            <= '0;
      tx_sh            <= '0;
      hold             <= '0;
      hold_valid       <= 1'b0;
      rx_byte_o        <= '0;
      rx_en_o          <= 1'b0;
      sel_start_o      <= 1'b0;
      sel_end_o        <= 1'b0;
      tx_underrun_o    <= 1'b0;
      busy_o           <= 1'b0;
      spi_miso_drive_o <= 1'b0;
    end else begin
      rx_en_o          <= 1'b0;
      sel_start_o      <= 1'b0;
      sel_end_o        <= 1'b0;
      tx_underrun_o    <= 1'b0;
      busy_o           <= ~csn_s;
      spi_miso_drive_o <= ~csn_s;

      if (sel_fall) begin
        bit_cnt     <= '0;
        sel_start_o <= 1'b1;
      end else if (sel_rise) begin
        bit_cnt   <= '0;
        sel_end_o <= 1'b1;
      end else if (rise) begin
        rx_sh   <= {rx_sh[5:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_byte_o <= {rx_sh, mosi_s};
          rx_en_o   <= 1'b1;
        end
      end

      if (load) begin
        if (hold_valid) begin
          tx_sh      <= hold;
          hold_valid <= 1'b0;
        end else begin
          tx_sh         <= FILL_BYTE;
          tx_underrun_o <= 1'b1;
        end
      end else if (fall && (bit_cnt != 3'd0)) begin
        tx_sh <= {tx_sh[6:0], 1'b0};
      end

      // A byte offered during an empty-hold load lands in hold, never in tx_sh.
      if (tx_en_i && !hold_valid) begin
        hold       <= tx_byte_i;
        hold_valid <= 1'b1;
      end
    end
  end

  assign spi_miso_o = tx_sh[7];
  assign tx_ready_o = ~hold_valid;

endmodule

// File: tb/tb_spi_target.sv
// Scoreboard bench for spi_target: a mode-0 controller model drives the pins,
// expected rx/miso bytes are queued as stimulus is issued and popped on output.
module tb_spi_target;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_clk_i, spi_csn_i, spi_mosi_i;
  logic       spi_miso_o, spi_miso_drive_o;
  logic [7:0] tx_byte_i;
  logic       tx_en_i;
  logic       tx_ready_o;
  logic [7:0] rx_byte_o;
  logic       rx_en_o, sel_start_o, sel_end_o, tx_underrun_o, busy_o;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned n_underrun = 0;
  int unsigned n_start = 0;
  int unsigned n_end = 0;
  logic [7:0] rx_exp[$];
  logic [7:0] miso_exp[$];

  spi_target #(.FILL_BYTE(8'hFF)) dut (
    .clk              (clk),
    .reset            (reset),
    .spi_clk_i        (spi_clk_i),
    .spi_csn_i        (spi_csn_i),
    .spi_mosi_i       (spi_mosi_i),
    .spi_miso_o       (spi_miso_o),
    .spi_miso_drive_o (spi_miso_drive_o),
    .tx_byte_i        (tx_byte_i),
    .tx_en_i          (tx_en_i),
    .tx_ready_o       (tx_ready_o),
    .rx_byte_o        (rx_byte_o),
    .rx_en_o          (rx_en_o),
    .sel_start_o      (sel_start_o),
    .sel_end_o        (sel_end_o),
    .tx_underrun_o    (tx_underrun_o),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: every rx_en_o pulse consumes one expected byte.
  always @(negedge clk) begin
    if (rx_en_o) begin
      logic [31:0] exp;
      exp = (rx_exp.size() != 0) ? 32'(rx_exp.pop_front()) : 'x;
      check("rx_byte", 32'(rx_byte_o), exp);
    end
    if (tx_underrun_o) n_underrun++;
    if (sel_start_o)   n_start++;
    if (sel_end_o)     n_end++;
  end

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] b);
    @(posedge clk);
    #1 tx_byte_i = b;
    tx_en_i = 1'b1;
    @(posedge clk);
    #1 tx_en_i = 1'b0;
  endtask

  task automatic select_dut();
    spi_csn_i = 1'b0;
    wait_cycles(6);
  endtask

  task automatic deselect_dut();
    wait_cycles(4);
    spi_csn_i = 1'b1;
    wait_cycles(8);
  endtask

  // Mode 0: MOSI set while SCLK low, MISO sampled just before each rise.
  task automatic spi_bits(input logic [7:0] b, input int unsigned n, output logic [7:0] got);
    got = '0;
    for (int unsigned i = 0; i < n; i++) begin
      spi_mosi_i = b[3'(7 - i)];
      wait_cycles(4);
      got = {got[6:0], spi_miso_o};
      spi_clk_i = 1'b1;
      wait_cycles(4);
      spi_clk_i = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b);
    logic [7:0]  got;
    logic [31:0] exp;
    rx_exp.push_back(b);
    spi_bits(b, 8, got);
    exp = (miso_exp.size() != 0) ? 32'(miso_exp.pop_front()) : 'x;
    check("miso_byte", 32'(got), exp);
  endtask

  initial begin
    int unsigned u0, s0, e0;
    logic [7:0]  got;

    reset = 1'b1;
    spi_clk_i = 1'b0;
    spi_csn_i = 1'b1;
    spi_mosi_i = 1'b0;
    tx_byte_i = '0;
    tx_en_i = 1'b0;
    wait_cycles(4);
    @(negedge clk);
    check("rst_tx_ready", 32'(tx_ready_o), 1);
    check("rst_rx_byte", 32'(rx_byte_o), 0);
    check("rst_miso", 32'(spi_miso_o), 0);
    check("rst_drive", 32'(spi_miso_drive_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_pulses", 32'({rx_en_o, sel_start_o, sel_end_o, tx_underrun_o}), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    wait_cycles(4);

    // Pre-queued exchange
    u0 = n_underrun; s0 = n_start; e0 = n_end;
    push_tx(8'hA5);
    check("t1_ready_full", 32'(tx_ready_o), 0);
    miso_exp.push_back(8'hA5);
    select_dut();
    check("t1_ready_back", 32'(tx_ready_o), 1);
    check("t1_busy", 32'(busy_o), 1);
    check("t1_drive", 32'(spi_miso_drive_o), 1);
    spi_byte(8'h3C);
    deselect_dut();
    check("t1_rx_pending", rx_exp.size(), 0);
    check("t1_rx_hold", 32'(rx_byte_o), 32'h3C);
    check("t1_sel_start", n_start - s0, 1);
    check("t1_sel_end", n_end - e0, 1);
    // only the trailing boundary load finds hold empty
    check("t1_underrun", n_underrun - u0, 1);
    check("t1_busy_off", 32'(busy_o), 0);

    // Underrun: select and boundary loads plus trailing load all see hold empty
    u0 = n_underrun;
    miso_exp.push_back(8'hFF);
    miso_exp.push_back(8'hFF);
    select_dut();
    spi_byte(8'h01);
    spi_byte(8'h02);
    deselect_dut();
    check("t2_rx_pending", rx_exp.size(), 0);
    check("t2_underrun", n_underrun - u0, 3);

    // Back-to-back with 8'h22 queued on byte-1 rx_en_o, well before the boundary fall
    u0 = n_underrun;
    push_tx(8'h11);
    miso_exp.push_back(8'h11);
    miso_exp.push_back(8'h22);
    select_dut();
    fork
      begin
        spi_byte(8'h22);
        spi_byte(8'h22);
      end
      begin : queue_second
        int unsigned k;
        k = 0;
        while (!rx_en_o && k < 400) begin
          @(negedge clk);
          k++;
        end
        check("t3_rx_en_seen", 32'(k < 400), 1);
        @(posedge clk);
        #1 tx_byte_i = 8'h22;
        tx_en_i = 1'b1;
        @(posedge clk);
        #1 tx_en_i = 1'b0;
      end
    join
    deselect_dut();
    check("t3_rx_pending", rx_exp.size(), 0);
    check("t3_underrun", n_underrun - u0, 1);

    // Abort after 5 rises, then a clean byte
    u0 = n_underrun; e0 = n_end;
    select_dut();
    spi_bits(8'hF0, 5, got);
    deselect_dut();
    check("t4_abort_end", n_end - e0, 1);
    check("t4_rx_after_abort", 32'(rx_byte_o), 32'h22);
    miso_exp.push_back(8'hFF);
    select_dut();
    spi_byte(8'hC3);
    deselect_dut();
    check("t4_rx_pending", rx_exp.size(), 0);
    check("t4_underrun", n_underrun - u0, 3);

    // Second tx_en_i while hold is full is dropped
    push_tx(8'h55);
    push_tx(8'hAA);
    check("t5_ready_full", 32'(tx_ready_o), 0);
    miso_exp.push_back(8'h55);
    select_dut();
    spi_byte(8'h5A);
    deselect_dut();
    check("t5_ready_empty", 32'(tx_ready_o), 1);
    check("t5_rx_pending", rx_exp.size(), 0);

    // Reset mid-byte with CSN held low
    select_dut();
    spi_bits(8'hA0, 3, got);
    wait_cycles(2);
    reset = 1'b1;
    wait_cycles(3);
    @(negedge clk);
    check("t6_rst_drive", 32'(spi_miso_drive_o), 0);
    check("t6_rst_busy", 32'(busy_o), 0);
    check("t6_rst_ready", 32'(tx_ready_o), 1);
    check("t6_rst_miso", 32'(spi_miso_o), 0);
    check("t6_rst_rx_byte", 32'(rx_byte_o), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    s0 = n_start; u0 = n_underrun;
    wait_cycles(6);
    check("t6_resel_start", n_start - s0, 1);
    deselect_dut();
    miso_exp.push_back(8'hFF);
    select_dut();
    spi_byte(8'h7E);
    deselect_dut();
    check("t6_rx_pending", rx_exp.size(), 0);
    check("t6_rx_byte", 32'(rx_byte_o), 32'h7E);
    check("t6_underrun", n_underrun - u0, 3);
    check("end_miso_pending", miso_exp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
